fir_transposed_tdm_mac: RTL
===========================

Name: fir_transposed_tdm_mac

Overview:
- Parametrised, time-multiplexed transposed-form FIR engine: next generation of the 10-tap MAC/accumulate block.
- One signed multiplier is shared across NTAP taps. Each sample strobe triggers one sweep that updates the transposed partial-sum registers and produces one filtered output.
- Coefficients are run-time writable. The output is shifted, optionally rounded, and saturated to OUT_W.
- Sits between the 600 kHz sample source and the downstream output register, all on the 12 MHz system clock.

Parameters:
- DATA_W, 16, signed input sample width
- COEF_W, 16, signed coefficient width
- NTAP, 10, number of taps; legal range 2..32; NTAP+2 must not exceed clocks per sample (20 at 12M/600k)
- ACC_W, 36, partial-sum width; must be ≥ DATA_W+COEF_W+clog2(NTAP)
- SHIFT, 15, arithmetic right shift applied to the tap-0 sum before saturation
- OUT_W, 16, signed output width

Ports:
- iClk_12M  in  1  system clock, rising edge
- iRsn  in  1  reset; synchronous, active-low
- iEnSample_600k  in  1  one-cycle sample strobe
- iFirIn  in  DATA_W  signed sample; valid with strobe
- iCoeffWe  in  1  coefficient write enable
- iCoeffAddr  in  clog2(NTAP)  tap index for write
- iCoeff  in  COEF_W  signed coefficient data
- iClrOvr  in  1  clears oOverrun
- oFirOut  out  OUT_W  signed filtered output, registered
- oValid  out  1  one-cycle pulse; new oFirOut
- oBusy  out  1  high in RUN and DONE
- oOverrun  out  1  sticky: strobe arrived while busy
- oWrDrop  out  1  one-cycle pulse: coefficient write rejected

Behaviour:
- Reset (iRsn=0 at an edge):
  - state goes to IDLE
  - all z[k] and coefficients go to 0
  - oFirOut=0, oValid=0, oOverrun=0, oWrDrop=0, oBusy=0
  - reset mid-sweep aborts the sweep with no oValid
- Algorithm, per sample x:
  - y = h0*x + z[1]
  - z[k] ← h_k*x + z[k+1] for k=1..NTAP-1, with z[NTAP]=0
  - taps processed in ascending k, one per clock, so z[k+1] is still the old value when read
- State machine:
  - IDLE: strobe sampled at edge E0 → latch iFirIn into rX, k=0, go to RUN.
  - RUN: the edge at E0+k+1 processes tap k. Tap 0 writes rY; taps k≥1 write z[k]. After tap NTAP-1 → DONE.
  - DONE: at edge E0+NTAP+1, oFirOut ← sat(rY>>>SHIFT) and oValid=1 for that one cycle → IDLE.
- Latency: oValid high in the cycle following edge E0+NTAP+1 (11 edges after the sampling edge for NTAP=10).
- Arithmetic:
  - product is full signed DATA_W+COEF_W, sign-extended to ACC_W
  - sums are ACC_W two's complement; no internal overflow by parameter rule
  - output: arithmetic shift by SHIFT, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
- Overrun:
  - a strobe sampled in RUN or DONE is dropped
  - oOverrun=1 from the next cycle; the current sweep is unaffected
  - iClrOvr=1 clears oOverrun; a simultaneous new overrun wins (stays 1)
- Coefficient writes:
  - accepted only in IDLE with iCoeffAddr<NTAP; take effect from the next sweep
  - a write in RUN/DONE, or with addr≥NTAP, is ignored and oWrDrop pulses one cycle
  - strobe and write in the same IDLE cycle: write is accepted and used by the sweep that starts on that edge

Optional Feature:
- Macro FIR_ROUND_EN.
- Defined: add 2^(SHIFT-1) to rY before the shift (round half up); no rounding when SHIFT=0.
- Undefined: plain arithmetic shift (truncate toward −∞).
- Saturation is present in both builds.

Test Plan:
- Impulse: SHIFT=0, h_k=k+1 (1..10), x=1 then zeros → oFirOut sequence 1,2,3,…,10,0; one oValid per strobe, 11 edges after strobe.
- Step: same coefficients, x=100 constant → 100,300,600,1000,…,5500, then 5500 steady.
- Saturation: SHIFT=15, all h=0x7FFF:
  - x=0x7FFF constant → 32766, then 32767 (saturated) thereafter
  - x=-32768 constant → -32767, then -32768 thereafter
- Rounding: SHIFT=15, h0=0x4000, other h=0, x=1 → output 1 with FIR_ROUND_EN, 0 without.
- Overrun/write drop:
  - second strobe 5 clocks after the first → oOverrun=1, no extra oValid, first result correct
  - iClrOvr → 0
  - coefficient write during RUN → oWrDrop pulse, next sweep uses the old value
- Reset mid-sweep: iRsn=0 at tap 4 → no oValid, all outputs 0; next impulse reproduces the impulse sequence from a cleared delay line.

Source files
------------

// File: rtl/fir_transposed_tdm_mac.sv
// Time-multiplexed transposed-form FIR: one shared signed multiplier sweeps NTAP taps per sample strobe.
// Define FIR_ROUND_EN to round half up before the output shift; saturation to OUT_W is always present.
`timescale 1ns/1ps
module fir_transposed_tdm_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int NTAP   = 10,
  parameter int ACC_W  = 36,
  parameter int SHIFT  = 15,
  parameter int OUT_W  = 16
) (
  input  logic                       iClk_12M,
  input  logic                       iRsn,
  input  logic                       iEnSample_600k,
  input  logic signed [DATA_W-1:0]   iFirIn,
  input  logic                       iCoeffWe,
  input  logic [$clog2(NTAP)-1:0]    iCoeffAddr,
  input  logic signed [COEF_W-1:0]   iCoeff,
  input  logic                       iClrOvr,
  output logic signed [OUT_W-1:0]    oFirOut,
  output logic                       oValid,
  output logic                       oBusy,
  output logic                       oOverrun,
  output logic                       oWrDrop
);

  localparam int AW = $clog2(NTAP);
  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAP - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT                     state;
  logic [AW-1:0]             tapIdx;
  logic signed [DATA_W-1:0]  rX;
  logic signed [ACC_W-1:0]   rY;
  logic signed [COEF_W-1:0]  coef [NTAP];
  // zReg[i] holds partial sum z[i+1]; z[NTAP] is the constant zero in zExt
  logic signed [ACC_W-1:0]   zReg [NTAP-1];
  logic signed [ACC_W-1:0]   zExt [NTAP];

  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   tapSum;
  logic signed [ACC_W-1:0]   rounded;
  logic signed [ACC_W-1:0]   shifted;
  logic [ACC_W-OUT_W:0]      topBits;
  logic                      satNeeded;
  logic signed [OUT_W-1:0]   satOut;

  always_comb begin
    for (int i = 0; i < NTAP - 1; i++) zExt[i] = zReg[i];
    zExt[NTAP-1] = '0;
  end

  assign prod   = PW'(coef[tapIdx]) * PW'(rX);
  assign tapSum = ACC_W'(prod) + zExt[tapIdx];

`ifdef FIR_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_BIAS = (ACC_W'(1) << SHIFT) >> 1;
  assign rounded = rY + RND_BIAS;
`else
  assign rounded = rY;
`endif

  // Saturate whenever the bits above the output sign bit are not a pure sign extension
  assign shifted   = rounded >>> SHIFT;
  assign topBits   = shifted[ACC_W-1:OUT_W-1];
  assign satNeeded = !((&topBits) || !(|topBits));
  assign satOut    = !satNeeded        ? shifted[OUT_W-1:0] :
                     shifted[ACC_W-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                         {1'b0, {(OUT_W-1){1'b1}}};

  assign oBusy = (state != IDLE);

  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      state    <= IDLE;
      tapIdx   <= '0;
      rX       <= '0;
      rY       <= '0;
      oFirOut  <= '0;
      oValid   <= 1'b0;
      oOverrun <= 1'b0;
      oWrDrop  <= 1'b0;
      for (int i = 0; i < NTAP; i++)     coef[i] <= '0;
      for (int i = 0; i < NTAP - 1; i++) zReg[i] <= '0;
    end else begin
      oValid  <= 1'b0;
      oWrDrop <= 1'b0;

      if (iCoeffWe) begin
        if (state == IDLE && 32'(iCoeffAddr) < NTAP) coef[iCoeffAddr] <= iCoeff;
        else oWrDrop <= 1'b1;
      end

      if (iEnSample_600k && state != IDLE) oOverrun <= 1'b1;
      else if (iClrOvr)                    oOverrun <= 1'b0;

      case (state)
        IDLE: begin
          if (iEnSample_600k) begin
            rX     <= iFirIn;
            tapIdx <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          // Ascending taps: z[k+1] is read here before its own tap overwrites it
          if (tapIdx == '0) rY <= tapSum;
          else              zReg[tapIdx - 1'b1] <= tapSum;
          if (tapIdx == LAST_TAP) state <= DONE;
          else                    tapIdx <= tapIdx + 1'b1;
        end
        DONE: begin
          oFirOut <= satOut;
          oValid  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
